// File: rtl/memory_stage.sv
// MEM pipeline stage: branch resolve, sub-word load/store on a local
// word-addressed data memory, and the MEM/WB pipeline register.
module memory_stage #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [31:0] AddResult,
  input  logic [4:0]  RegDstAddress,
  input  logic        Zero,
  input  logic        SignBit,
  input  logic        Branch,
  input  logic        RegWrite,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        MemToReg,
  input  logic [1:0]  BitSel,
  input  logic [2:0]  BranchLogicOp,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic [31:0] ReadData_W,
  output logic [31:0] ALUResult_W,
  output logic [4:0]  RegDstAddress_W,
  output logic        RegWrite_W,
  output logic        MemToReg_W
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [15:0]   half;
  logic [7:0]    byt;
  logic [31:0]   load;
  logic [31:0]   mask;
  logic [31:0]   wdata;
  logic          cond;
  logic          unused_addr;

  assign idx  = ALUResult[AW+1:2];
  assign word = mem[idx];
  assign half = ALUResult[1] ? word[31:16] : word[15:0];
  assign byt  = word[{ALUResult[1:0], 3'b000} +: 8];

  // address bits above the array wrap silently
  assign unused_addr = ^ALUResult[31:AW+2];

  always_comb begin
    cond = 1'b0;
    case (BranchLogicOp)
      3'b000:  cond = Zero;
      3'b001:  cond = !Zero;
      3'b010:  cond = !SignBit && !Zero;
      3'b011:  cond = SignBit || Zero;
      3'b100:  cond = SignBit;
      3'b101:  cond = !SignBit;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrc        = Branch & cond;
  assign BranchTarget = AddResult;

  always_comb begin
    load  = word;
    mask  = 32'hFFFF_FFFF;
    wdata = WriteData;
    case (BitSel)
      2'b01: begin
        load  = {{16{half[15]}}, half};
        mask  = ALUResult[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdata = {2{WriteData[15:0]}};
      end
      2'b10: begin
        load  = {{24{byt[7]}}, byt};
        mask  = 32'h0000_00FF << {ALUResult[1:0], 3'b000};
        wdata = {4{WriteData[7:0]}};
      end
      default: load = word;
    endcase
    if (!MemRead) load = 32'h0;
  end

  // lane merge keeps untouched bytes of the word
  always_ff @(posedge Clk) begin
    if (Reset && MemWrite && !Stall)
      mem[idx] <= (word & ~mask) | (wdata & mask);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ReadData_W      <= 32'h0;
      ALUResult_W     <= 32'h0;
      RegDstAddress_W <= 5'h0;
      RegWrite_W      <= 1'b0;
      MemToReg_W      <= 1'b0;
    end else if (!Stall) begin
      ReadData_W      <= load;
      ALUResult_W     <= ALUResult;
      RegDstAddress_W <= RegDstAddress;
      RegWrite_W      <= RegWrite;
      MemToReg_W      <= MemToReg;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: branch table, directed load/store sequences
// and random traffic against a byte-array reference model.
module tb_memory_stage;

  localparam int MEM_WORDS = 1024;
  localparam int NBYTES = MEM_WORDS * 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] AddResult = '0;
  logic [4:0]  RegDstAddress = '0;
  logic        Zero = 1'b0;
  logic        SignBit = 1'b0;
  logic        Branch = 1'b0;
  logic        RegWrite = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemToReg = 1'b0;
  logic [1:0]  BitSel = '0;
  logic [2:0]  BranchLogicOp = '0;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] ReadData_W;
  logic [31:0] ALUResult_W;
  logic [4:0]  RegDstAddress_W;
  logic        RegWrite_W;
  logic        MemToReg_W;

  memory_stage #(.MEM_WORDS(MEM_WORDS)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .AddResult(AddResult), .RegDstAddress(RegDstAddress),
    .Zero(Zero), .SignBit(SignBit), .Branch(Branch),
    .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemToReg(MemToReg),
    .BitSel(BitSel), .BranchLogicOp(BranchLogicOp),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .ReadData_W(ReadData_W), .ALUResult_W(ALUResult_W),
    .RegDstAddress_W(RegDstAddress_W),
    .RegWrite_W(RegWrite_W), .MemToReg_W(MemToReg_W)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mb [NBYTES];
  bit         kn [NBYTES];

  logic [31:0] m_rd, m_alu;
  logic [4:0]  m_rda;
  logic        m_rw, m_m2r;
  bit          m_rdk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ne(input string name, input logic [31:0] act,
                        input logic [31:0] bad);
    vectors++;
    if (act === bad) begin
      miscompares++;
      $display("FAIL %s: got %h, must differ from %h", name, act, bad);
    end
  endtask

  function automatic int acc_size(input logic [1:0] sel);
    if (sel == 2'b01) return 2;
    if (sel == 2'b10) return 1;
    return 4;
  endfunction

  function automatic bit ref_branch(input logic [2:0] op,
                                    input logic z, input logic s);
    case (op)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return !s && !z;
      3'd3: return s || z;
      3'd4: return s;
      3'd5: return !s;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_load(output logic [31:0] v, output bit k);
    int unsigned sz, a, base;
    sz = acc_size(BitSel);
    a = ALUResult % NBYTES;
    base = a - (a % sz);
    v = '0;
    k = 1;
    for (int i = 0; i < int'(sz); i++) begin
      v = v | (32'(mb[base + i]) << (8 * i));
      if (!kn[base + i]) k = 0;
    end
    if (sz == 2) v = {{16{v[15]}}, v[15:0]};
    if (sz == 1) v = {{24{v[7]}}, v[7:0]};
    if (!MemRead) begin
      v = '0;
      k = 1;
    end
  endtask

  task automatic model_store();
    int unsigned sz, a, base;
    sz = acc_size(BitSel);
    a = ALUResult % NBYTES;
    base = a - (a % sz);
    for (int i = 0; i < int'(sz); i++) begin
      mb[base + i] = WriteData[8*i +: 8];
      kn[base + i] = 1;
    end
  endtask

  // One clock: check combinational outputs, advance model, check MEM/WB.
  task automatic cycle();
    logic [31:0] ld;
    bit k;
    #1;
    chk("pcsrc", {31'b0, PCSrc},
        {31'b0, Branch & ref_branch(BranchLogicOp, Zero, SignBit)});
    chk("target", BranchTarget, AddResult);
    model_load(ld, k);
    if (!Reset) begin
      m_rd = '0; m_rdk = 1; m_alu = '0; m_rda = '0;
      m_rw = 0; m_m2r = 0;
    end else if (!Stall) begin
      m_rd = ld; m_rdk = k; m_alu = ALUResult;
      m_rda = RegDstAddress; m_rw = RegWrite; m_m2r = MemToReg;
      if (MemWrite) model_store();
    end
    @(posedge Clk);
    #1;
    if (m_rdk) chk("read_w", ReadData_W, m_rd);
    chk("alu_w", ALUResult_W, m_alu);
    chk("rd_w", {27'b0, RegDstAddress_W}, {27'b0, m_rda});
    chk("rw_w", {31'b0, RegWrite_W}, {31'b0, m_rw});
    chk("m2r_w", {31'b0, MemToReg_W}, {31'b0, m_m2r});
  endtask

  task automatic set_mem(input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sel, input logic mw,
                         input logic mr);
    ALUResult = addr; WriteData = wd; BitSel = sel;
    MemWrite = mw; MemRead = mr; MemToReg = mr; RegWrite = mr;
    RegDstAddress = 5'd3; Branch = 0;
  endtask

  typedef struct {
    logic [2:0] op;
    logic br, z, s, st;
    logic exp;
  } br_vec_t;

  br_vec_t bt [16];

  initial begin
    for (int i = 0; i < NBYTES; i++) begin
      mb[i] = '0;
      kn[i] = 0;
    end
    bt[0]  = '{3'd0, 1, 1, 0, 0, 1};
    bt[1]  = '{3'd1, 1, 1, 0, 0, 0};
    bt[2]  = '{3'd2, 1, 1, 0, 0, 0};
    bt[3]  = '{3'd3, 1, 1, 0, 0, 1};
    bt[4]  = '{3'd4, 1, 1, 0, 0, 0};
    bt[5]  = '{3'd5, 1, 1, 0, 0, 1};
    bt[6]  = '{3'd6, 1, 1, 0, 0, 0};
    bt[7]  = '{3'd7, 1, 1, 0, 0, 0};
    bt[8]  = '{3'd0, 0, 1, 0, 0, 0};
    bt[9]  = '{3'd3, 0, 1, 0, 0, 0};
    bt[10] = '{3'd2, 1, 0, 1, 0, 0};
    bt[11] = '{3'd3, 1, 0, 1, 0, 1};
    bt[12] = '{3'd4, 1, 0, 1, 0, 1};
    bt[13] = '{3'd5, 1, 0, 1, 0, 0};
    bt[14] = '{3'd1, 1, 0, 1, 1, 1};
    bt[15] = '{3'd2, 1, 0, 0, 1, 1};

    // reset with a store pending
    Reset = 0;
    set_mem(32'h10, 32'hDEADBEEF, 2'b00, 1, 0);
    RegWrite = 1;
    repeat (2) begin
      cycle();
      chk("rst_read", ReadData_W, 32'h0);
      chk("rst_alu", ALUResult_W, 32'h0);
      chk("rst_rw", {31'b0, RegWrite_W}, 32'h0);
    end
    Reset = 1;
    set_mem(32'h10, 32'h0, 2'b00, 0, 1);
    cycle();
    chk_ne("rst_nostore", ReadData_W, 32'hDEADBEEF);

    // word then sub-word stores
    set_mem(32'h20, 32'h11223344, 2'b00, 1, 0); cycle();
    set_mem(32'h21, 32'h123456AA, 2'b10, 1, 0); cycle();
    set_mem(32'h22, 32'h77778001, 2'b01, 1, 0); cycle();
    set_mem(32'h20, 32'h0, 2'b00, 0, 1); cycle();
    chk("ld_word", ReadData_W, 32'h8001AA44);
    set_mem(32'h21, 32'h0, 2'b10, 0, 1); cycle();
    chk("ld_byte21", ReadData_W, 32'hFFFFFFAA);
    set_mem(32'h22, 32'h0, 2'b01, 0, 1); cycle();
    chk("ld_half22", ReadData_W, 32'hFFFF8001);
    set_mem(32'h20, 32'h0, 2'b10, 0, 1); cycle();
    chk("ld_byte20", ReadData_W, 32'h00000044);

    // branch decode table
    AddResult = 32'h40;
    foreach (bt[i]) begin
      BranchLogicOp = bt[i].op; Branch = bt[i].br;
      Zero = bt[i].z; SignBit = bt[i].s; Stall = bt[i].st;
      #1;
      chk($sformatf("branch%0d", i), {31'b0, PCSrc}, {31'b0, bt[i].exp});
    end
    chk("target40", BranchTarget, 32'h40);
    Stall = 0; Branch = 0;

    // stall holds register and blocks stores
    set_mem(32'h20, 32'h0, 2'b00, 0, 1);
    Stall = 1;
    repeat (2) begin
      cycle();
      chk("stall_hold", ReadData_W, 32'h00000044);
    end
    set_mem(32'h20, 32'hCAFEF00D, 2'b00, 1, 0);
    cycle();
    Stall = 0;
    set_mem(32'h20, 32'h0, 2'b00, 0, 1);
    cycle();
    chk("stall_release", ReadData_W, 32'h8001AA44);

    // address wrap and pass-through
    set_mem(32'h00001000, 32'h55, 2'b00, 1, 0); cycle();
    set_mem(32'h0, 32'h0, 2'b00, 0, 1); cycle();
    chk("wrap", ReadData_W, 32'h00000055);
    set_mem(32'h12345678, 32'h0, 2'b00, 0, 0);
    RegDstAddress = 5'd9; RegWrite = 1;
    cycle();
    chk("pass_alu", ALUResult_W, 32'h12345678);
    chk("pass_rd", {27'b0, RegDstAddress_W}, 32'd9);
    chk("pass_rw", {31'b0, RegWrite_W}, 32'd1);
    chk("pass_read", ReadData_W, 32'h0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      ALUResult = $urandom & 32'hFFFF_F03F;
      WriteData = $urandom;
      AddResult = $urandom;
      RegDstAddress = 5'($urandom);
      {Zero, SignBit, Branch, RegWrite, MemToReg} = 5'($urandom);
      MemWrite = ($urandom_range(0, 2) == 0);
      MemRead = $urandom_range(0, 1) == 1;
      BitSel = 2'($urandom);
      BranchLogicOp = 3'($urandom);
      Stall = ($urandom_range(0, 4) == 0);
      Reset = ($urandom_range(0, 30) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage: consumes the registered EX results (ALU result, store data, branch target, flags, control bits) and resolves conditional branches. It performs byte/half/word loads and stores against an internal word-addressed data memory, then presents the MEM/WB pipeline register to write-back. It sits between the EX/MEM register and the write-back mux; the PC source select feeds back to fetch.

## Interface
- MEM_WORDS, 1024, data memory depth in 32-bit words (power of two)
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-low reset
- Stall  input  1  hold MEM/WB register and suppress stores this cycle
- ALUResult  input  32  byte address for loads/stores; pass-through result otherwise
- WriteData  input  32  store data (rt value)
- AddResult  input  32  branch target from EX
- RegDstAddress  input  5  destination register
- Zero, SignBit  input  1 each  ALU flags from EX
- Branch, RegWrite, MemWrite, MemRead, MemToReg  input  1 each  control
- BitSel  input  2  access size: 00 word, 01 half, 10 byte, 11 treated as word
- BranchLogicOp  input  3  branch condition select
- PCSrc  output  1  branch taken (combinational)
- BranchTarget  output  32  equals AddResult (combinational)
- ReadData_W  output  32  registered load data
- ALUResult_W  output  32  registered ALUResult
- RegDstAddress_W  output  5  registered destination
- RegWrite_W, MemToReg_W  output  1 each  registered control

## Operation
- Branch condition (cond), by BranchLogicOp:
  - 000 beq: Zero
  - 001 bne: !Zero
  - 010 bgtz: !SignBit & !Zero
  - 011 blez: SignBit | Zero
  - 100 bltz: SignBit
  - 101 bgez: !SignBit
  - 110/111: 0
- PCSrc = Branch & cond. Independent of Stall and Reset.
- Word index = ALUResult[log2(MEM_WORDS)+1:2]; higher address bits ignored (wrap). Byte order little-endian.
- Word access ignores ALUResult[1:0]. Half access selects lane ALUResult[1] (0 = bits 15:0), ignores bit 0. Byte access selects lane ALUResult[1:0].
- Load data:
  - Word access: the full word.
  - Half/byte access: the selected lane, sign-extended to 32 bits.
  - MemRead=0: load data is 0.
- Store (MemWrite=1, Stall=0, Reset=1):
  - At posedge, write only the addressed lane(s) with the low bits of WriteData.
  - Other lanes of the word are unchanged.
- Memory read is asynchronous from the array. A load and store in the same cycle returns pre-write contents.
- MEM/WB register captures at posedge when Stall=0 and Reset=1. With Stall=1 it holds all values.
- Memory contents are not initialised or cleared by reset.

## Timing
- Reset low at posedge: all *_W outputs go to 0, and any store that cycle is suppressed. Reset mid-stall also clears.
- Load latency: one cycle. Address presented in cycle N; ReadData_W is valid after posedge ending cycle N.
- A store at posedge N is visible to a load presented in cycle N+1.
- PCSrc/BranchTarget have zero latency, combinational from inputs.
- Stall and MemWrite together: no write, register unchanged. Stall has no effect on PCSrc.

## Test plan
- Reset: hold Reset=0 two cycles with MemWrite=1, addr 0x10, data 0xDEADBEEF; release and load word 0x10. Required: all *_W = 0 during reset; loaded word is not 0xDEADBEEF (X/initial contents).
- Word then sub-word stores:
  - Store word 0x11223344 at 0x20, then byte 0xAA at 0x21, then half 0x8001 at 0x22.
  - Load word 0x20: 0x8001AA44.
  - Load byte 0x21: 0xFFFFFFAA.
  - Load half 0x22: 0xFFFF8001.
  - Load byte 0x20: 0x00000044.
- Branch decode:
  - Branch=1, Zero=1, SignBit=0: PCSrc = 1 for ops 000, 011, 101; 0 for ops 001, 010, 100, 110.
  - Branch=0, any op: PCSrc = 0.
  - BranchTarget tracks AddResult (0x00000040).
- Stall:
  - Present load of 0x20 with Stall=1 for 2 cycles: ReadData_W holds its previous value.
  - Store with Stall=1: memory unchanged.
  - Release Stall: 0x8001AA44 appears next cycle.
- Wrap/pass-through:
  - With MEM_WORDS=1024, store 0x55 word at 0x00001000; load word 0x0: 0x00000055.
  - Non-memory op ALUResult=0x12345678, RegDstAddress=9, RegWrite=1: registered unchanged one cycle later, ReadData_W = 0.
